// File: rtl/regfile_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_ctrl
//  Description : Register-file write-port controller. After reset it sweeps
//                INIT_VAL into every register. It then arbitrates two write
//                requesters (A and B) onto a single registered write port
//                using round-robin priority.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_ctrl #(
  parameter int            NREGS    = 32,
  parameter int            DW       = 64,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [4:0]    a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [4:0]    b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          write,
  output logic [4:0]    wrAddr,
  output logic [DW-1:0] wrData,
  output logic          init_busy
);

  localparam int AW = 5;
  localparam int CW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NREGS - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Identity of the most recently accepted requester.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          run_ok;
  logic          a_xfer;
  logic          b_xfer;

  // Grants are masked by rst so that a handshake in a reset cycle never occurs.
  assign run_ok    = (state == ST_RUN) && !rst;
  assign a_ready   = run_ok && a_valid && (!b_valid || (last == LAST_B));
  assign b_ready   = run_ok && b_valid && (!a_valid || (last == LAST_A));
  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign init_busy = (state == ST_INIT) || rst;

  // Init sweep, arbitration bookkeeping and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      last   <= LAST_B;
      write  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          write  <= 1'b1;
          wrAddr <= AW'(cnt);
          wrData <= INIT_VAL;
          if (cnt == LAST_IDX) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (a_xfer) begin
            write  <= 1'b1;
            wrAddr <= a_addr;
            wrData <= a_data;
            last   <= LAST_A;
          end else if (b_xfer) begin
            write  <= 1'b1;
            wrAddr <= b_addr;
            wrData <= b_data;
            last   <= LAST_B;
          end else begin
            write  <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
